// File: rtl/fast_shutter_pkg.sv
// Shared constants for the fast shutter command sequencer: FSM encoding,
// request source identifiers and default timing values.
package fast_shutter_pkg;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ISSUE  = 2'd1;
  localparam logic [1:0] S_WAIT   = 2'd2;
  localparam logic [1:0] S_SETTLE = 2'd3;

  typedef enum logic [1:0] {
    IDLE   = S_IDLE,
    ISSUE  = S_ISSUE,
    WAIT   = S_WAIT,
    SETTLE = S_SETTLE
  } state_t;

  localparam logic SRC_HW = 1'b0;
  localparam logic SRC_SW = 1'b1;

  // 20 ms at 100 MHz; the settle gap covers the driver coil pulse window.
  localparam int DEF_TIMEOUT_CYCLES = 2000000;
  localparam int DEF_SETTLE_CYCLES  = 524288;
  localparam int DEF_CNT_W          = 32;

endpackage

// File: rtl/fast_shutter_req_latch.sv
// One request source: a pending flag plus the latest requested target.
// A new request in the accept cycle keeps the entry pending with the new value.
module fast_shutter_req_latch (
  input  logic clk_i,
  input  logic rst_i,
  input  logic req_i,
  input  logic set_i,
  input  logic accept_i,
  output logic pending_o,
  output logic target_o
);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pending_o <= 1'b0;
      target_o  <= 1'b0;
    end else if (req_i) begin
      pending_o <= 1'b1;
      target_o  <= set_i;
    end else if (accept_i) begin
      pending_o <= 1'b0;
    end
  end

endmodule

// File: rtl/fast_shutter_seq.sv
// Fast shutter command sequencer: arbitrates hw/sw open/close requests, strobes
// the driver, times the actuation, flags timeouts and enforces a settle gap.
module fast_shutter_seq
  import fast_shutter_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int SETTLE_CYCLES  = DEF_SETTLE_CYCLES,
  parameter int CNT_W          = DEF_CNT_W
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             hw_req_i,
  input  logic             hw_set_i,
  input  logic             sw_req_i,
  input  logic             sw_set_i,
  input  logic             err_clr_i,
  input  logic             fast_shutter_state_i,
  output logic             fast_shutter_en_o,
  output logic             fast_shutter_set_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             done_src_o,
  output logic             timeout_err_o,
  output logic [CNT_W-1:0] act_time_o
);

  localparam logic [CNT_W-1:0] TO_LAST     = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_VAL      = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] act_q, act_d;
  logic             tgt_q, tgt_d;
  logic             src_q, src_d;
  logic             err_q, err_d;
  logic             hw_pend, hw_tgt, sw_pend, sw_tgt;
  logic             hw_accept, sw_accept;
  logic             issue, finish;

  fast_shutter_req_latch u_hw_req (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .req_i     (hw_req_i),
    .set_i     (hw_set_i),
    .accept_i  (hw_accept),
    .pending_o (hw_pend),
    .target_o  (hw_tgt)
  );

  fast_shutter_req_latch u_sw_req (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .req_i     (sw_req_i),
    .set_i     (sw_set_i),
    .accept_i  (sw_accept),
    .pending_o (sw_pend),
    .target_o  (sw_tgt)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      act_q   <= '0;
      tgt_q   <= 1'b0;
      src_q   <= SRC_HW;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      act_q   <= act_d;
      tgt_q   <= tgt_d;
      src_q   <= src_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    act_d     = act_q;
    tgt_d     = tgt_q;
    src_d     = src_q;
    err_d     = err_q;
    hw_accept = 1'b0;
    sw_accept = 1'b0;
    issue     = 1'b0;
    finish    = 1'b0;

    // Clear first so a timeout in the same cycle overrides it.
    if (err_clr_i) err_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (hw_pend) begin
          tgt_d     = hw_tgt;
          src_d     = SRC_HW;
          hw_accept = 1'b1;
          state_d   = ISSUE;
        end else if (sw_pend) begin
          tgt_d     = sw_tgt;
          src_d     = SRC_SW;
          sw_accept = 1'b1;
          state_d   = ISSUE;
        end
      end
      ISSUE: begin
        issue   = 1'b1;
        cnt_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        if (fast_shutter_state_i == tgt_q) begin
          act_d   = cnt_q;
          finish  = 1'b1;
          cnt_d   = CNT_W'(1);
          state_d = SETTLE;
        end else if (cnt_q == TO_LAST) begin
          err_d   = 1'b1;
          act_d   = TO_VAL;
          finish  = 1'b1;
          cnt_d   = CNT_W'(1);
          state_d = SETTLE;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      SETTLE: begin
        // The completion cycle counts as the first settle cycle.
        if (cnt_q >= SETTLE_LAST) state_d = IDLE;
        else                      cnt_d   = cnt_q + CNT_W'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  assign fast_shutter_en_o  = issue & ~rst_i;
  assign fast_shutter_set_o = tgt_q;
  assign busy_o             = (state_q != IDLE);
  assign done_o             = finish & ~rst_i;
  assign done_src_o         = done_o & src_q;
  assign timeout_err_o      = err_q;
  assign act_time_o         = act_q;

endmodule

// File: tb/tb_fast_shutter_seq.sv
// Self-checking bench for fast_shutter_seq: directed scenarios plus randomized
// request traffic scored against a transaction-level model of the sequencer.
module tb_fast_shutter_seq;

  localparam int TO  = 100;
  localparam int ST  = 16;
  localparam int CW  = 32;
  localparam int LEN = 300;
  localparam int END = 750;

  logic          clk = 1'b0;
  logic          rst_i = 1'b1;
  logic          hw_req_i = 1'b0, hw_set_i = 1'b0;
  logic          sw_req_i = 1'b0, sw_set_i = 1'b0;
  logic          err_clr_i = 1'b0;
  logic          fb = 1'b0;
  logic          fast_shutter_en_o, fast_shutter_set_o, busy_o, done_o, done_src_o, timeout_err_o;
  logic [CW-1:0] act_time_o;

  fast_shutter_seq #(.TIMEOUT_CYCLES(TO), .SETTLE_CYCLES(ST), .CNT_W(CW)) dut (
    .clk_i                (clk),
    .rst_i                (rst_i),
    .hw_req_i             (hw_req_i),
    .hw_set_i             (hw_set_i),
    .sw_req_i             (sw_req_i),
    .sw_set_i             (sw_set_i),
    .err_clr_i            (err_clr_i),
    .fast_shutter_state_i (fb),
    .fast_shutter_en_o    (fast_shutter_en_o),
    .fast_shutter_set_o   (fast_shutter_set_o),
    .busy_o               (busy_o),
    .done_o               (done_o),
    .done_src_o           (done_src_o),
    .timeout_err_o        (timeout_err_o),
    .act_time_o           (act_time_o)
  );

  always #5 clk = ~clk;

  int          checks = 0, failures = 0;
  int          cyc = 0;
  logic [31:0] obs_strobe_q[$], obs_done_q[$], obs_act_q[$];
  logic [31:0] exp_strobe_q[$], exp_done_q[$], exp_act_q[$];
  int          dq[$];
  logic        prev_done = 1'b0, prev_busy = 1'b0;
  int          busy_fall_cyc = -1;
  logic        plant_armed = 1'b0, plant_val = 1'b0;
  int          plant_at = 0;

  // One clock cycle: observe outputs mid-cycle, then advance past the edge and
  // let the shutter plant move the feedback when its actuation delay expires.
  task automatic tick();
    int d;
    @(negedge clk);
    if (prev_done) obs_act_q.push_back(act_time_o);
    if (fast_shutter_en_o) begin
      obs_strobe_q.push_back({cyc[30:0], fast_shutter_set_o});
      d = (dq.size() > 0) ? dq.pop_front() : 1000;
      if (fb != fast_shutter_set_o && d < TO) begin
        plant_armed = 1'b1;
        plant_at    = cyc + 1 + d;
        plant_val   = fast_shutter_set_o;
      end
    end
    if (done_o) obs_done_q.push_back({cyc[30:0], done_src_o});
    if (prev_busy && !busy_o) busy_fall_cyc = cyc;
    prev_done = done_o;
    prev_busy = busy_o;
    @(posedge clk);
    #1;
    cyc++;
    if (plant_armed && cyc == plant_at) begin
      fb          = plant_val;
      plant_armed = 1'b0;
    end
  endtask

  task automatic clear_obs();
    obs_strobe_q.delete();
    obs_done_q.delete();
    obs_act_q.delete();
    busy_fall_cyc = -1;
  endtask

  task automatic wait_done(input int n, input int budget, output bit ok);
    int b;
    b = budget;
    while (obs_done_q.size() < n && b > 0) begin
      tick();
      b--;
    end
    ok = (obs_done_q.size() >= n);
    tick();
  endtask

  task automatic wait_idle(input int budget, output bit ok);
    int b;
    b = budget;
    while (busy_o && b > 0) begin
      tick();
      b--;
    end
    ok = !busy_o;
    tick();
  endtask

  task automatic do_reset();
    rst_i = 1'b1; hw_req_i = 1'b0; sw_req_i = 1'b0; err_clr_i = 1'b0;
    plant_armed = 1'b0;
    tick(); tick();
    rst_i = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    tick(); tick(); tick();
    checks++; if (fast_shutter_en_o !== 1'b0) begin failures++; $display("FAIL reset_en got=%b exp=0", fast_shutter_en_o); end
    checks++; if (fast_shutter_set_o !== 1'b0) begin failures++; $display("FAIL reset_set got=%b exp=0", fast_shutter_set_o); end
    checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy_o); end
    checks++; if (done_o !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done_o); end
    checks++; if (done_src_o !== 1'b0) begin failures++; $display("FAIL reset_done_src got=%b exp=0", done_src_o); end
    checks++; if (timeout_err_o !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", timeout_err_o); end
    checks++; if (act_time_o !== '0) begin failures++; $display("FAIL reset_act got=%0d exp=0", act_time_o); end
    rst_i = 1'b0;
    tick(); tick();
    checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL reset_idle_after got=%b exp=0", busy_o); end
  endtask

  task automatic test_basic();
    int n, s, d;
    bit ok;
    clear_obs(); dq = '{10};
    n = cyc; sw_set_i = 1'b1; sw_req_i = 1'b1; tick(); sw_req_i = 1'b0;
    wait_done(1, 200, ok);
    checks++; if (!ok) begin failures++; $display("FAIL basic_done_timeout got=%0d exp=1", obs_done_q.size()); end
    wait_idle(100, ok);
    checks++; if (!ok) begin failures++; $display("FAIL basic_idle_timeout got=busy exp=idle"); end
    s = obs_strobe_q[0][31:1]; d = obs_done_q[0][31:1];
    checks++; if (obs_strobe_q.size() !== 1) begin failures++; $display("FAIL basic_strobe_count got=%0d exp=1", obs_strobe_q.size()); end
    checks++; if (s !== n + 2) begin failures++; $display("FAIL basic_strobe_cyc got=%0d exp=%0d", s, n + 2); end
    checks++; if (obs_strobe_q[0][0] !== 1'b1) begin failures++; $display("FAIL basic_strobe_set got=%b exp=1", obs_strobe_q[0][0]); end
    checks++; if (d !== n + 13) begin failures++; $display("FAIL basic_done_cyc got=%0d exp=%0d", d, n + 13); end
    checks++; if (obs_done_q[0][0] !== 1'b1) begin failures++; $display("FAIL basic_done_src got=%b exp=1", obs_done_q[0][0]); end
    checks++; if (obs_act_q[0] !== 32'd10) begin failures++; $display("FAIL basic_act got=%0d exp=10", obs_act_q[0]); end
    checks++; if (busy_fall_cyc !== d + 16) begin failures++; $display("FAIL basic_busy_fall got=%0d exp=%0d", busy_fall_cyc, d + 16); end
    checks++; if (fast_shutter_set_o !== 1'b1) begin failures++; $display("FAIL basic_set_hold got=%b exp=1", fast_shutter_set_o); end
  endtask

  task automatic test_simultaneous();
    int n, d0, s1;
    bit ok;
    clear_obs(); dq = '{3, 4};
    n = cyc;
    hw_set_i = 1'b0; hw_req_i = 1'b1; sw_set_i = 1'b1; sw_req_i = 1'b1;
    tick();
    hw_req_i = 1'b0; sw_req_i = 1'b0;
    wait_done(2, 400, ok);
    checks++; if (!ok) begin failures++; $display("FAIL sim_done_timeout got=%0d exp=2", obs_done_q.size()); end
    d0 = obs_done_q[0][31:1]; s1 = obs_strobe_q[1][31:1];
    checks++; if (obs_strobe_q.size() !== 2) begin failures++; $display("FAIL sim_strobe_count got=%0d exp=2", obs_strobe_q.size()); end
    checks++; if (obs_strobe_q[0] !== {31'(n + 2), 1'b0}) begin failures++; $display("FAIL sim_first_strobe got=%0h exp=%0h", obs_strobe_q[0], {31'(n + 2), 1'b0}); end
    checks++; if (obs_done_q[0] !== {31'(n + 6), 1'b0}) begin failures++; $display("FAIL sim_first_done got=%0h exp=%0h", obs_done_q[0], {31'(n + 6), 1'b0}); end
    checks++; if (obs_act_q[0] !== 32'd3) begin failures++; $display("FAIL sim_first_act got=%0d exp=3", obs_act_q[0]); end
    checks++; if (s1 !== d0 + 17) begin failures++; $display("FAIL sim_second_strobe_cyc got=%0d exp=%0d", s1, d0 + 17); end
    checks++; if (obs_strobe_q[1][0] !== 1'b1) begin failures++; $display("FAIL sim_second_set got=%b exp=1", obs_strobe_q[1][0]); end
    checks++; if (obs_done_q[1] !== {31'(s1 + 5), 1'b1}) begin failures++; $display("FAIL sim_second_done got=%0h exp=%0h", obs_done_q[1], {31'(s1 + 5), 1'b1}); end
    checks++; if (obs_act_q[1] !== 32'd4) begin failures++; $display("FAIL sim_second_act got=%0d exp=4", obs_act_q[1]); end
    wait_idle(100, ok);
  endtask

  task automatic test_timeout();
    int n;
    bit ok;
    fb = 1'b0;
    clear_obs(); dq = '{1000};
    n = cyc; sw_set_i = 1'b1; sw_req_i = 1'b1; tick(); sw_req_i = 1'b0;
    wait_done(1, 300, ok);
    checks++; if (!ok) begin failures++; $display("FAIL to_done_timeout got=%0d exp=1", obs_done_q.size()); end
    checks++; if (obs_done_q[0] !== {31'(n + 2 + TO), 1'b1}) begin failures++; $display("FAIL to_done got=%0h exp=%0h", obs_done_q[0], {31'(n + 2 + TO), 1'b1}); end
    checks++; if (obs_act_q[0] !== 32'(TO)) begin failures++; $display("FAIL to_act got=%0d exp=%0d", obs_act_q[0], TO); end
    checks++; if (timeout_err_o !== 1'b1) begin failures++; $display("FAIL to_err_set got=%b exp=1", timeout_err_o); end
    wait_idle(100, ok);
    tick(); tick();
    checks++; if (timeout_err_o !== 1'b1) begin failures++; $display("FAIL to_err_sticky got=%b exp=1", timeout_err_o); end
    err_clr_i = 1'b1; tick(); err_clr_i = 1'b0;
    checks++; if (timeout_err_o !== 1'b0) begin failures++; $display("FAIL to_err_clear got=%b exp=0", timeout_err_o); end
    // err_clr_i coincident with a fresh timeout: the timeout must win.
    clear_obs(); dq = '{1000};
    n = cyc; hw_set_i = 1'b1; hw_req_i = 1'b1; tick(); hw_req_i = 1'b0;
    while (cyc < n + 2 + TO) tick();
    err_clr_i = 1'b1; tick(); err_clr_i = 1'b0;
    checks++; if (obs_done_q.size() !== 1 || obs_done_q[0] !== {31'(n + 2 + TO), 1'b0}) begin failures++; $display("FAIL to2_done got=%0h exp=%0h", obs_done_q[0], {31'(n + 2 + TO), 1'b0}); end
    checks++; if (timeout_err_o !== 1'b1) begin failures++; $display("FAIL to2_set_wins got=%b exp=1", timeout_err_o); end
    wait_idle(100, ok);
  endtask

  task automatic test_reset_mid_wait();
    int s, b;
    clear_obs(); dq = '{1000};
    fb = 1'b0;
    hw_set_i = 1'b1; hw_req_i = 1'b1; tick(); hw_req_i = 1'b0;
    b = 20;
    while (obs_strobe_q.size() == 0 && b > 0) begin tick(); b--; end
    checks++; if (obs_strobe_q.size() !== 1) begin failures++; $display("FAIL rmw_strobe got=%0d exp=1", obs_strobe_q.size()); end
    s = obs_strobe_q[0][31:1];
    while (cyc < s + 2) tick();
    hw_set_i = 1'b0; hw_req_i = 1'b1; tick(); hw_req_i = 1'b0;
    while (cyc < s + 5) tick();
    rst_i = 1'b1; tick(); rst_i = 1'b0;
    checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL rmw_busy got=%b exp=0", busy_o); end
    checks++; if (act_time_o !== '0) begin failures++; $display("FAIL rmw_act got=%0d exp=0", act_time_o); end
    checks++; if (timeout_err_o !== 1'b0) begin failures++; $display("FAIL rmw_err got=%b exp=0", timeout_err_o); end
    repeat (40) tick();
    checks++; if (obs_strobe_q.size() !== 1) begin failures++; $display("FAIL rmw_no_strobe got=%0d exp=1", obs_strobe_q.size()); end
    checks++; if (obs_done_q.size() !== 0) begin failures++; $display("FAIL rmw_no_done got=%0d exp=0", obs_done_q.size()); end
  endtask

  task automatic test_overwrite();
    int d0, s1;
    bit ok;
    fb = 1'b1;
    clear_obs(); dq = '{5, 1000};
    sw_set_i = 1'b0; sw_req_i = 1'b1; tick(); sw_req_i = 1'b0;
    wait_done(1, 200, ok);
    checks++; if (!ok || busy_o !== 1'b1) begin failures++; $display("FAIL ow_first_done got=%0d exp=1", obs_done_q.size()); end
    sw_set_i = 1'b1; sw_req_i = 1'b1; tick();
    sw_set_i = 1'b0; tick(); sw_req_i = 1'b0;
    wait_done(2, 200, ok);
    wait_idle(100, ok);
    repeat (5) tick();
    d0 = obs_done_q[0][31:1]; s1 = obs_strobe_q[1][31:1];
    checks++; if (obs_strobe_q.size() !== 2) begin failures++; $display("FAIL ow_strobe_count got=%0d exp=2", obs_strobe_q.size()); end
    checks++; if (obs_strobe_q[1][0] !== 1'b0) begin failures++; $display("FAIL ow_latest_set got=%b exp=0", obs_strobe_q[1][0]); end
    checks++; if (s1 !== d0 + 17) begin failures++; $display("FAIL ow_strobe_cyc got=%0d exp=%0d", s1, d0 + 17); end
    checks++; if (obs_done_q.size() !== 2 || obs_done_q[1] !== {31'(s1 + 1), 1'b1}) begin failures++; $display("FAIL ow_done got=%0h exp=%0h", obs_done_q[1], {31'(s1 + 1), 1'b1}); end
    checks++; if (obs_act_q[1] !== 32'd0) begin failures++; $display("FAIL ow_act_zero got=%0d exp=0", obs_act_q[1]); end
  endtask

  task automatic test_random(input int iter);
    bit   hr[LEN], hs[LEN], sr[LEN], ss[LEN];
    int   dl[64];
    int   base, free_at, k;
    bit   hp, sp, hv, sv, errm;
    logic fbm;
    do_reset();
    fb = 1'($urandom_range(0, 1));
    clear_obs(); dq.delete();
    exp_strobe_q.delete(); exp_done_q.delete(); exp_act_q.delete();
    for (int c = 0; c < LEN; c++) begin
      hr[c] = ($urandom_range(0, 24) == 0); hs[c] = 1'($urandom_range(0, 1));
      sr[c] = ($urandom_range(0, 19) == 0); ss[c] = 1'($urandom_range(0, 1));
    end
    for (int i = 0; i < 64; i++) begin
      dl[i] = ($urandom_range(0, 7) == 0) ? 150 : $urandom_range(0, 30);
      dq.push_back(dl[i]);
    end
    base = cyc;
    // Transaction model: a request seen at c-1 is pending at c; an idle
    // sequencer takes hw before sw, strobes next cycle, and is free again
    // ST cycles after completion.
    hp = 0; sp = 0; hv = 0; sv = 0; errm = 0; free_at = 0; k = 0; fbm = fb;
    for (int c = 1; c < END; c++) begin
      if (c - 1 < LEN) begin
        if (hr[c-1]) begin hp = 1; hv = hs[c-1]; end
        if (sr[c-1]) begin sp = 1; sv = ss[c-1]; end
      end
      if (c >= free_at && (hp || sp)) begin
        bit v, src;
        int act, dc;
        if (hp) begin v = hv; src = 0; hp = 0; end
        else    begin v = sv; src = 1; sp = 0; end
        exp_strobe_q.push_back({31'(base + c + 1), v});
        if (fbm == v)       begin act = 0;     dc = c + 2 + act; end
        else if (dl[k] < TO) begin act = dl[k]; dc = c + 2 + act; fbm = v; end
        else                begin act = TO;    dc = c + 1 + TO; errm = 1; end
        k++;
        exp_done_q.push_back({31'(base + dc), src});
        exp_act_q.push_back(32'(act));
        free_at = dc + ST;
      end
    end
    for (int c = 0; c < END; c++) begin
      hw_req_i = (c < LEN) ? hr[c] : 1'b0; hw_set_i = (c < LEN) ? hs[c] : 1'b0;
      sw_req_i = (c < LEN) ? sr[c] : 1'b0; sw_set_i = (c < LEN) ? ss[c] : 1'b0;
      tick();
    end
    checks++; if (obs_strobe_q.size() !== exp_strobe_q.size()) begin failures++; $display("FAIL rnd%0d_strobe_count got=%0d exp=%0d", iter, obs_strobe_q.size(), exp_strobe_q.size()); end
    checks++; if (obs_done_q.size() !== exp_done_q.size()) begin failures++; $display("FAIL rnd%0d_done_count got=%0d exp=%0d", iter, obs_done_q.size(), exp_done_q.size()); end
    for (int i = 0; i < exp_strobe_q.size() && i < obs_strobe_q.size(); i++) begin
      checks++; if (obs_strobe_q[i] !== exp_strobe_q[i]) begin failures++; $display("FAIL rnd%0d_strobe[%0d] got=%0h exp=%0h", iter, i, obs_strobe_q[i], exp_strobe_q[i]); end
    end
    for (int i = 0; i < exp_done_q.size() && i < obs_done_q.size() && i < obs_act_q.size(); i++) begin
      checks++; if (obs_done_q[i] !== exp_done_q[i]) begin failures++; $display("FAIL rnd%0d_done[%0d] got=%0h exp=%0h", iter, i, obs_done_q[i], exp_done_q[i]); end
      checks++; if (obs_act_q[i] !== exp_act_q[i]) begin failures++; $display("FAIL rnd%0d_act[%0d] got=%0d exp=%0d", iter, i, obs_act_q[i], exp_act_q[i]); end
    end
    checks++; if (timeout_err_o !== errm) begin failures++; $display("FAIL rnd%0d_err got=%b exp=%b", iter, timeout_err_o, errm); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_simultaneous();
    test_timeout();
    test_reset_mid_wait();
    test_overwrite();
    for (int it = 0; it < 3; it++) test_random(it);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
